// File: rtl/except_pkg.sv
// Shared definitions for the MEM-stage exception arbiter: exception codes,
// FSM state type and bit positions inside exc_flags_i.
package except_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS     = 32'h0000_0008;
    localparam logic [31:0] EXC_BP      = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
    localparam logic [31:0] EXC_IF_ADEL = 32'h0000_000f;

    localparam int FLG_W       = 9;
    localparam int FLG_IF_ADEL = 8;
    localparam int FLG_RI      = 7;
    localparam int FLG_OV      = 6;
    localparam int FLG_TRAP    = 5;
    localparam int FLG_SYS     = 4;
    localparam int FLG_BP      = 3;
    localparam int FLG_ADEL    = 2;
    localparam int FLG_ADES    = 1;
    localparam int FLG_ERET    = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } except_state_t;

    // Interrupt is deliverable only with IE set, outside exception/error level.
    function automatic logic int_pending(input logic [7:0] im, input logic [7:0] ip,
                                         input logic ie, input logic exl, input logic erl);
        return ie & ~exl & ~erl & (|(im & ip));
    endfunction

endpackage

// File: rtl/except_ctrl_irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines (used with IRQ_SYNC_EN).
module irq_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Metastability chain: two back-to-back flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= {WIDTH{1'b0}};
            s2_q <= {WIDTH{1'b0}};
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter and one-cycle flush sequencer feeding CP0.
// Optional macro IRQ_SYNC_EN: route hw_int_i through a 2-flop synchroniser.
module except_ctrl
    import except_pkg::*;
#(
    parameter int INT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] hw_int_i,
    input  logic             timer_int_i,
    output logic [INT_W-1:0] int_o,
    input  logic             mem_valid_i,
    input  logic             mem_stall_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_in_delayslot_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [FLG_W-1:0] exc_flags_i,
    input  logic [31:0]      status_i,
    input  logic [31:0]      cause_i,
    input  logic [31:0]      vector_i,
    output logic [31:0]      except_type_o,
    output logic [31:0]      pc_o,
    output logic             in_delayslot_o,
    output logic [31:0]      mem_addr_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o
);

    except_state_t    state_q, state_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [31:0]      except_type_s;
    logic             commit_s;
    logic             int_pending_s;
    logic [INT_W-1:0] hw_int_s;
    logic             unused_bits;

`ifdef IRQ_SYNC_EN
    irq_sync #(.WIDTH(INT_W)) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d_i (hw_int_i),
        .q_o (hw_int_s)
    );
`else
    assign hw_int_s = hw_int_i;
`endif

    // The timer shares the top line and is already synchronous to clk.
    assign int_o = {hw_int_s[INT_W-1] | timer_int_i, hw_int_s[INT_W-2:0]};

    assign int_pending_s = int_pending(status_i[15:8], cause_i[15:8],
                                       status_i[0], status_i[1], status_i[2]);

    // Only one commit per instruction: never while stalled, flushing or in reset.
    assign commit_s = mem_valid_i & ~mem_stall_i & (state_q == IDLE) & ~rst;

    assign unused_bits = ^{status_i[31:16], status_i[7:3], cause_i[31:16], cause_i[7:0]};

    // Fixed-priority exception encoder; interrupts beat synchronous exceptions.
    always_comb begin
        except_type_s = EXC_NONE;
        if (!commit_s) begin
            except_type_s = EXC_NONE;
        end else if (int_pending_s) begin
            except_type_s = EXC_INT;
        end else if (exc_flags_i[FLG_IF_ADEL]) begin
            except_type_s = EXC_IF_ADEL;
        end else if (exc_flags_i[FLG_RI]) begin
            except_type_s = EXC_RI;
        end else if (exc_flags_i[FLG_OV]) begin
            except_type_s = EXC_OV;
        end else if (exc_flags_i[FLG_TRAP]) begin
            except_type_s = EXC_TRAP;
        end else if (exc_flags_i[FLG_SYS]) begin
            except_type_s = EXC_SYS;
        end else if (exc_flags_i[FLG_BP]) begin
            except_type_s = EXC_BP;
        end else if (exc_flags_i[FLG_ADEL]) begin
            except_type_s = EXC_ADEL;
        end else if (exc_flags_i[FLG_ADES]) begin
            except_type_s = EXC_ADES;
        end else if (exc_flags_i[FLG_ERET]) begin
            except_type_s = EXC_ERET;
        end else begin
            except_type_s = EXC_NONE;
        end
    end

    // Next-state logic: a taken exception latches the CP0 vector and flushes for one cycle.
    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        case (state_q)
            IDLE: begin
                if (except_type_s != EXC_NONE) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = vector_i;
                end else begin
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered flush/redirect outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign except_type_o  = except_type_s;
    assign pc_o           = mem_pc_i;
    assign in_delayslot_o = mem_in_delayslot_i;
    assign mem_addr_o     = mem_addr_i;
    assign flush_o        = flush_q;
    assign new_pc_o       = new_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl (default or IRQ_SYNC_EN build).
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int_i;
    logic        timer_int_i;
    logic [5:0]  int_o;
    logic        mem_valid_i;
    logic        mem_stall_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] vector_i;
    logic [31:0] except_type_o;
    logic [31:0] pc_o;
    logic        in_delayslot_o;
    logic [31:0] mem_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int n_checks = 0;
    int n_errors = 0;

    // flag one-hots, bit order {if_adel, ri, ov, trap, sys, bp, adel, ades, eret}
    localparam logic [8:0] F_IFADEL = 9'b1_0000_0000;
    localparam logic [8:0] F_RI     = 9'b0_1000_0000;
    localparam logic [8:0] F_OV     = 9'b0_0100_0000;
    localparam logic [8:0] F_TRAP   = 9'b0_0010_0000;
    localparam logic [8:0] F_SYS    = 9'b0_0001_0000;
    localparam logic [8:0] F_BP     = 9'b0_0000_1000;
    localparam logic [8:0] F_ADEL   = 9'b0_0000_0100;
    localparam logic [8:0] F_ADES   = 9'b0_0000_0010;
    localparam logic [8:0] F_ERET   = 9'b0_0000_0001;

    except_ctrl #(.INT_W(6)) dut (
        .clk                (clk),
        .rst                (rst),
        .hw_int_i           (hw_int_i),
        .timer_int_i        (timer_int_i),
        .int_o              (int_o),
        .mem_valid_i        (mem_valid_i),
        .mem_stall_i        (mem_stall_i),
        .mem_pc_i           (mem_pc_i),
        .mem_in_delayslot_i (mem_in_delayslot_i),
        .mem_addr_i         (mem_addr_i),
        .exc_flags_i        (exc_flags_i),
        .status_i           (status_i),
        .cause_i            (cause_i),
        .vector_i           (vector_i),
        .except_type_o      (except_type_o),
        .pc_o               (pc_o),
        .in_delayslot_o     (in_delayslot_o),
        .mem_addr_o         (mem_addr_o),
        .flush_o            (flush_o),
        .new_pc_o           (new_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic valid, input logic stall, input logic [8:0] flags);
        mem_valid_i = valid;
        mem_stall_i = stall;
        exc_flags_i = flags;
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        hw_int_i           = 6'd0;
        timer_int_i        = 1'b0;
        mem_valid_i        = 1'b0;
        mem_stall_i        = 1'b0;
        mem_pc_i           = 32'h0000_0000;
        mem_in_delayslot_i = 1'b0;
        mem_addr_i         = 32'h0000_0000;
        exc_flags_i        = 9'd0;
        status_i           = 32'h0000_0000;
        cause_i            = 32'h0000_0000;
        vector_i           = 32'h0000_0000;
        step();
        step();
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_newpc", new_pc_o, 32'd0);
        check("rst_type", except_type_o, 32'd0);
        rst = 1'b0;
        step();

        // syscall, then flush, then back-to-back retake at T+2
        mem_pc_i = 32'hbfc0_0010; mem_in_delayslot_i = 1'b1; mem_addr_i = 32'h0000_1234;
        vector_i = 32'hbfc0_0380;
        set_mem(1'b1, 1'b0, F_SYS);
        check("sys_type", except_type_o, 32'h08);
        check("sys_pc", pc_o, 32'hbfc0_0010);
        check("sys_ds", {31'd0, in_delayslot_o}, 32'd1);
        check("sys_addr", mem_addr_o, 32'h0000_1234);
        step();
        check("sys_flush", {31'd0, flush_o}, 32'd1);
        check("sys_newpc", new_pc_o, 32'hbfc0_0380);
        check("sys_type_T1", except_type_o, 32'd0);
        step();
        check("b2b_flush_done", {31'd0, flush_o}, 32'd0);
        check("b2b_type", except_type_o, 32'h08);
        set_mem(1'b0, 1'b0, 9'd0);
        step();
        step();

        // ov + ades with a 3-cycle stall
        set_mem(1'b1, 1'b1, F_OV | F_ADES);
        for (int i = 0; i < 3; i++) begin
            check("stall_type", except_type_o, 32'd0);
            step();
            check("stall_flush", {31'd0, flush_o}, 32'd0);
        end
        set_mem(1'b1, 1'b0, F_OV | F_ADES);
        check("ov_ades_type", except_type_o, 32'h0c);
        set_mem(1'b0, 1'b0, 9'd0);
        step();

        // priority table (no clock edge taken while valid)
        set_mem(1'b1, 1'b0, F_IFADEL | F_RI);  check("pri_ifadel", except_type_o, 32'h0f);
        set_mem(1'b1, 1'b0, F_RI | F_OV);      check("pri_ri", except_type_o, 32'h0a);
        set_mem(1'b1, 1'b0, F_TRAP | F_SYS);   check("pri_trap", except_type_o, 32'h0d);
        set_mem(1'b1, 1'b0, F_BP | F_ADEL);    check("pri_bp", except_type_o, 32'h09);
        set_mem(1'b1, 1'b0, F_ADEL | F_ADES);  check("pri_adel", except_type_o, 32'h04);
        set_mem(1'b1, 1'b0, F_ADES | F_ERET);  check("pri_ades", except_type_o, 32'h05);
        set_mem(1'b1, 1'b0, 9'd0);             check("pri_none", except_type_o, 32'h00);

        // interrupt beats sync exception; masked by EXL; bubble never takes it
        status_i = 32'h0000_ff01; cause_i = 32'h0000_8000;
        set_mem(1'b1, 1'b0, F_SYS);   check("int_type", except_type_o, 32'h01);
        status_i = 32'h0000_ff03; #1; check("int_exl", except_type_o, 32'h08);
        status_i = 32'h0000_ff01;
        set_mem(1'b0, 1'b0, 9'd0);    check("int_bubble", except_type_o, 32'h00);
        step();
        check("int_bubble_noflush", {31'd0, flush_o}, 32'd0);
        status_i = 32'h0000_0000; cause_i = 32'h0000_0000;

        // eret redirects through the vector
        vector_i = 32'h8000_1234;
        set_mem(1'b1, 1'b0, F_ERET);
        check("eret_type", except_type_o, 32'h0e);
        step();
        check("eret_flush", {31'd0, flush_o}, 32'd1);
        check("eret_newpc", new_pc_o, 32'h8000_1234);
        set_mem(1'b0, 1'b0, 9'd0);
        step();

        // reset in FLUSH, then sys one cycle after reset
        vector_i = 32'hbfc0_0380;
        set_mem(1'b1, 1'b0, F_SYS);
        step();
        check("pre_rst_flush", {31'd0, flush_o}, 32'd1);
        rst = 1'b1;
        set_mem(1'b0, 1'b0, 9'd0);
        step();
        rst = 1'b0;
        check("rstfl_flush", {31'd0, flush_o}, 32'd0);
        check("rstfl_newpc", new_pc_o, 32'd0);
        set_mem(1'b1, 1'b0, F_SYS);
        check("post_rst_type", except_type_o, 32'h08);
        step();
        check("post_rst_flush", {31'd0, flush_o}, 32'd1);
        check("post_rst_newpc", new_pc_o, 32'hbfc0_0380);
        set_mem(1'b0, 1'b0, 9'd0);
        step();

        // interrupt line conditioning
        timer_int_i = 1'b1; #1;
        check("timer_int", {26'd0, int_o}, 32'h20);
        timer_int_i = 1'b0; #1;
        hw_int_i = 6'b000100; #1;
`ifdef IRQ_SYNC_EN
        check("hw_sync_0", {26'd0, int_o}, 32'h00);
        step();
        check("hw_sync_1", {26'd0, int_o}, 32'h00);
        step();
        check("hw_sync_2", {26'd0, int_o}, 32'h04);
`else
        check("hw_pass", {26'd0, int_o}, 32'h04);
        hw_int_i = 6'b100001; #1;
        check("hw_pass_top", {26'd0, int_o}, 32'h21);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
